// File: rtl/demux_dispatch_ctrl.sv
// Round-robin dispatcher: one-entry holding register feeding 2^S valid/ready lanes,
// advancing the channel select after BURST delivered words and skipping masked channels.
module demux_dispatch_ctrl #(
  parameter int S     = 3,
  parameter int T     = 1,
  parameter int BURST = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [T-1:0]         i_in_data,
  input  logic [(1<<S)-1:0]    i_chan_mask,
  output logic [(1<<S)-1:0]    o_out_valid,
  input  logic [(1<<S)-1:0]    i_out_ready,
  output logic [(1<<S)*T-1:0]  o_out_data,
  output logic [S-1:0]         o_ctrl,
  output logic                 o_busy
);

  localparam int N = 1 << S;
  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // First enabled channel after cur (wrapping), cur itself last; cur if none enabled.
  function automatic logic [S-1:0] f_next_en(input logic [S-1:0] cur, input logic [N-1:0] mask);
    logic [S-1:0] res;
    logic [S-1:0] idx;
    res = cur;
    for (int d = N; d >= 1; d--) begin
      idx = cur + S'(d);
      if (mask[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [0:0]   r_state;
  logic [T-1:0] r_hold;
  logic [S-1:0] r_ctrl;
  logic [7:0]   r_cnt;

  logic [0:0]   w_state_nxt;
  logic [T-1:0] w_hold_nxt;
  logic [S-1:0] w_ctrl_nxt;
  logic [7:0]   w_cnt_nxt;

  logic         w_full;
  logic         w_fire_out;
  logic         w_fire_in;
  logic         w_in_ready;
  logic         w_skip;
  logic         w_burst_end;
  logic [S-1:0] w_next_en;

  assign w_full      = (r_state == ST_FULL);
  assign w_fire_out  = w_full & i_out_ready[r_ctrl];
  // Ready is judged against the pre-advance select, so it never depends on i_in_valid.
  assign w_in_ready  = i_chan_mask[r_ctrl] & (~w_full | w_fire_out);
  assign w_fire_in   = i_in_valid & w_in_ready;
  assign w_skip      = ~w_full & ~i_chan_mask[r_ctrl] & (|i_chan_mask);
  assign w_burst_end = (r_cnt == BURST_LAST);
  assign w_next_en   = f_next_en(r_ctrl, i_chan_mask);

  assign o_in_ready = w_in_ready;
  assign o_ctrl     = r_ctrl;
  assign o_busy     = w_full;

  // Next-state logic for the holding register, channel select and burst counter.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_ctrl_nxt  = r_ctrl;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_EMPTY: begin
        if (w_fire_in) begin
          w_state_nxt = ST_FULL;
          w_hold_nxt  = i_in_data;
        end else if (w_skip) begin
          w_ctrl_nxt = w_next_en;
          w_cnt_nxt  = 8'd0;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_fire_out) begin
          if (w_burst_end) begin
            w_cnt_nxt  = 8'd0;
            w_ctrl_nxt = w_next_en;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
          if (w_fire_in) begin
            w_hold_nxt = i_in_data;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_hold  <= '0;
      r_ctrl  <= '0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Lane decode: only the selected lane carries valid and the held word.
  always_comb begin
    o_out_valid = '0;
    o_out_data  = '0;
    for (int k = 0; k < N; k++) begin
      if (S'(k) == r_ctrl) begin
        o_out_valid[k]        = w_full;
        o_out_data[k*T +: T]  = r_hold;
      end else begin
        o_out_valid[k]        = 1'b0;
        o_out_data[k*T +: T]  = '0;
      end
    end
  end

endmodule
